// File: rtl/bb_uart_frame_rx.sv
// UART frame receiver: 2-flop synchroniser, mid-bit sampling, {mode,data,addr} payload LSB first.
// Good frames land on a held output with a level ready flag; bad stop bits park the FSM in BREAK.
module bb_uart_frame_rx #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int RX_DATA_WIDTH    = 21
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx,
    output logic                     ready,
    output logic [RX_DATA_WIDTH-1:0] data_output,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int CW   = $clog2(CLOCKS_PER_PULSE);
    localparam int IW   = (RX_DATA_WIDTH > 1) ? $clog2(RX_DATA_WIDTH) : 1;
    localparam int HALF = CLOCKS_PER_PULSE / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(RX_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_BREAK,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_rx_meta;
    logic                     r_rx_s;
    logic [1:0]               r_sync_vld;
    logic [CW-1:0]            r_cnt;
    logic [IW-1:0]            r_idx;
    logic [RX_DATA_WIDTH-1:0] r_shift;
    logic [RX_DATA_WIDTH-1:0] r_data;
    logic                     r_ready;
    logic                     r_ferr;
    logic                     r_busy;
    logic                     w_bit_end;
    logic                     w_half;
    logic                     w_line_up;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_half    = (r_cnt == CNT_HALF);
    // The synchroniser flops reset to 1; only trust a high line once real samples have reached rx_s,
    // otherwise a line held low through reset would look idle for two cycles and start a frame.
    assign w_line_up = r_rx_s && r_sync_vld[1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BREAK: if (w_line_up) w_next = S_IDLE;
            S_IDLE:  if (!r_rx_s) w_next = S_START;
            S_START: if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_end && (r_idx == IDX_LAST)) w_next = S_STOP;
            S_STOP:  if (w_bit_end) w_next = r_rx_s ? S_IDLE : S_BREAK;
            default: w_next = S_BREAK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_sync_vld <= '0;
            r_state    <= S_BREAK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_state    <= w_next;
            r_busy     <= (w_next != S_IDLE);

            if ((w_next != r_state) || w_bit_end) r_cnt <= '0;
            else                                  r_cnt <= r_cnt + CW'(1);

            case (r_state)
                S_START: begin
                    // ready drops only on a validated start, so a glitch leaves the last frame visible
                    if (w_half && !r_rx_s) begin
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift[r_idx] <= r_rx_s;
                        if (r_idx != IDX_LAST) r_idx <= r_idx + IW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_ready <= 1'b1;
                            r_ferr  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = r_ready;
    assign data_output = r_data;
    assign frame_err   = r_ferr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_bb_uart_frame_rx.sv
// Directed bench for bb_uart_frame_rx at 16 clocks per bit, 21-bit frames.
// Expected values are hand-derived from the frame layout and the T0+HALF+22*CPP latency.
module tb_bb_uart_frame_rx;

    localparam int CPP = 16;
    localparam int W   = 21;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rx;
    logic         ready;
    logic [W-1:0] data_output;
    logic         frame_err;
    logic         busy;

    int n_chk = 0;
    int n_bad = 0;

    int cyc       = 0;
    int t_start   = 0;
    int rise_cyc  = -1;
    int fall_cyc  = -1;
    int bfall_cyc = -1;
    int rises     = 0;
    int busy_hi   = 0;
    logic ready_q = 1'b0;
    logic busy_q  = 1'b0;

    bb_uart_frame_rx #(
        .CLOCKS_PER_PULSE(CPP),
        .RX_DATA_WIDTH   (W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .ready      (ready),
        .data_output(data_output),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // edge observer, sampled mid-cycle
    always @(negedge clk) begin
        if (ready && !ready_q) begin
            rises    = rises + 1;
            rise_cyc = cyc;
        end
        if (!ready && ready_q) fall_cyc = cyc;
        if (!busy && busy_q) bfall_cyc = cyc;
        if (busy) busy_hi = busy_hi + 1;
        ready_q = ready;
        busy_q  = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // entered and left 1ns after a rising edge
    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stopb);
        t_start = cyc;
        drive(1'b0, CPP);
        for (int i = 0; i < W; i++) drive(d[i], CPP);
        drive(stopb, CPP);
    endtask

    initial begin
        int t1;
        int r0;
        int b0;
        logic [W-1:0] part;

        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_data", 32'(data_output), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        drive(1'b1, 10);
        chk("idle_busy", 32'(busy), 32'd0);

        // good write frame
        send_frame(21'h1A53C7, 1'b1);
        chk("good_lat", 32'(rise_cyc - t_start), 32'd363);
        chk("good_data", 32'(data_output), 32'h1A53C7);
        chk("good_ready", 32'(ready), 32'd1);
        chk("good_ferr", 32'(frame_err), 32'd0);
        chk("good_busy_edge", 32'(bfall_cyc), 32'(rise_cyc));
        drive(1'b1, 10);

        // glitch: 3 low cycles are rejected at the half-bit check
        b0 = busy_hi;
        drive(1'b0, 3);
        drive(1'b1, 20);
        chk("glitch_busy_cyc", 32'(busy_hi - b0), 32'd8);
        chk("glitch_ready", 32'(ready), 32'd1);
        chk("glitch_data", 32'(data_output), 32'h1A53C7);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_rises", 32'(rises), 32'd1);

        // framing error followed by a held-low line
        send_frame(21'h000FFF, 1'b0);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_ready", 32'(ready), 32'd0);
        chk("ferr_data", 32'(data_output), 32'h1A53C7);
        drive(1'b0, 40);
        chk("ferr_break_busy", 32'(busy), 32'd1);
        chk("ferr_rises", 32'(rises), 32'd1);
        drive(1'b1, 20);
        chk("ferr_idle_busy", 32'(busy), 32'd0);
        send_frame(21'h0ABCDE, 1'b1);
        chk("ferr_clr", 32'(frame_err), 32'd0);
        chk("ferr_next_data", 32'(data_output), 32'h0ABCDE);
        chk("ferr_next_ready", 32'(ready), 32'd1);
        drive(1'b1, 10);

        // back-to-back frames, no idle between stop and next start
        r0 = rises;
        send_frame(21'h000001, 1'b1);
        t1 = t_start;
        chk("b2b_first_data", 32'(data_output), 32'h000001);
        chk("b2b_first_lat", 32'(rise_cyc - t1), 32'd363);
        send_frame(21'h1FFFFF, 1'b1);
        chk("b2b_fall", 32'(fall_cyc - t_start), 32'd11);
        chk("b2b_rises", 32'(rises - r0), 32'd2);
        chk("b2b_data", 32'(data_output), 32'h1FFFFF);
        drive(1'b1, 10);

        // reset during DATA idx 10 with the line held low
        part = 21'h155555;
        t_start = cyc;
        drive(1'b0, CPP);
        for (int i = 0; i < 10; i++) drive(part[i], CPP);
        rx   = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_data", 32'(data_output), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        r0 = rises;
        drive(1'b0, 30);
        chk("mid_break_busy", 32'(busy), 32'd1);
        chk("mid_break_ferr", 32'(frame_err), 32'd0);
        drive(1'b1, 20);
        chk("mid_idle_busy", 32'(busy), 32'd0);
        send_frame(21'h155555, 1'b1);
        chk("mid_next_data", 32'(data_output), 32'h155555);
        chk("mid_next_ready", 32'(ready), 32'd1);
        chk("mid_next_rises", 32'(rises - r0), 32'd1);
        drive(1'b1, 10);

        // release reset with the line held low
        rstn = 1'b0;
        rx   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        r0 = rises;
        drive(1'b0, 100);
        chk("low_rel_busy", 32'(busy), 32'd1);
        chk("low_rel_ready", 32'(ready), 32'd0);
        chk("low_rel_ferr", 32'(frame_err), 32'd0);
        chk("low_rel_rises", 32'(rises - r0), 32'd0);
        drive(1'b1, 20);
        chk("low_rel_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bb_uart_frame_rx.md
Name: bb_uart_frame_rx

Overview:
- UART receive front end that feeds the bus bridge master's command FIFO.
- Deserialises one wide frame per transaction, laid out as {mode, data, addr}, LSB first, with a single start bit and a single stop bit.
- Presents each frame on a held parallel output with a level `ready` flag. The consumer edge-detects `ready` to enqueue.
- Detects false start bits and framing errors, and discards bad frames.

Parameters:
- CLOCKS_PER_PULSE, 5208: clk cycles per UART bit; minimum 4.
- RX_DATA_WIDTH, 21: frame payload bits, equal to DATA_WIDTH + BB_ADDR_WIDTH + 1.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- rx  input  1  serial line, asynchronous, idle high
- ready  output  1  level; high while data_output holds a newly received good frame
- data_output  output  RX_DATA_WIDTH  last good frame payload; bit 0 = first data bit on the line
- frame_err  output  1  high after a frame whose stop bit sampled 0; cleared by the next good frame
- busy  output  1  high in every state except IDLE

Behaviour:
- Synchroniser:
  - rx passes through 2 flops to give rx_s.
  - Both flops reset to 1.
  - All decisions use rx_s only.
- Bit timer: counter cnt, width clog2(CLOCKS_PER_PULSE), cleared on every state change. Bit index idx runs 0..RX_DATA_WIDTH-1.
- HALF = CLOCKS_PER_PULSE/2, integer floor.
- States: BREAK, IDLE, START, DATA, STOP.
- BREAK:
  - Entered on reset and after a framing error.
  - Waits for rx_s==1, then moves to IDLE.
  - A line held low at reset release never starts a frame.
- IDLE:
  - When rx_s==0 goes to START; cnt <= 0.
- START:
  - At cnt==HALF-1, samples rx_s.
  - If 0: valid start. Go to DATA, idx <= 0, ready <= 0.
  - If 1: glitch. Return to IDLE; ready and data_output are unchanged.
- DATA:
  - At cnt==CLOCKS_PER_PULSE-1, shift[idx] <= rx_s.
  - If idx==RX_DATA_WIDTH-1, go to STOP; otherwise idx++.
- STOP, at cnt==CLOCKS_PER_PULSE-1:
  - If rx_s==1: data_output <= shift, ready <= 1, frame_err <= 0, go to IDLE.
  - If rx_s==0: frame_err <= 1, data_output and ready are unchanged (ready is already 0), go to BREAK.
- Sampling point: the sample lands mid-bit for each data bit and for the stop bit.
- Latency:
  - Let T0 be the clk edge at which IDLE sees rx_s==0.
  - ready and data_output update at edge T0 + HALF + (RX_DATA_WIDTH+1)*CLOCKS_PER_PULSE.
  - rx pin to rx_s adds 2 cycles.
- ready lifetime:
  - Stays high through IDLE and any following glitch rejection.
  - Falls only when the next start bit is validated.
  - Guarantees at least one low cycle between consecutive frames, so a rising-edge consumer sees exactly one edge per good frame.
- Back-to-back frames: a start bit immediately after the stop sample is accepted. IDLE is occupied for 1 cycle minimum.
- No flow control: a frame overwrites data_output even if the previous one was not consumed. The consumer must edge-detect within one frame time.
- Reset (rstn==0 at a clk edge), including mid-frame:
  - state <= BREAK, cnt <= 0, idx <= 0, shift <= 0.
  - ready <= 0, data_output <= 0, frame_err <= 0, busy <= 0.
  - Partial frames are discarded.
- busy is registered with the state (combinational decode of the state register is acceptable).

Test Plan (CLOCKS_PER_PULSE=16, RX_DATA_WIDTH=21, HALF=8):
- Good write frame, payload {1, 8'hA5, 12'h3C7} = 21'h1A53C7 → ready rises at T0+360; data_output==21'h1A53C7; frame_err==0; busy drops the same edge.
- Glitch: rx low for 3 cycles, then high → no START→DATA transition; ready and data_output unchanged; state returns to IDLE; busy high for ≤9 cycles.
- Framing error: payload 21'h000FFF with stop bit driven 0, then the line held low for 40 cycles, then high → frame_err==1, data_output keeps its previous value, ready stays 0; no new frame starts until rx returns high; the next good frame 21'h0ABCDE clears frame_err and sets ready.
- Back-to-back: frames 21'h000001 and 21'h1FFFFF with zero idle between them → ready pulses high, falls at the second start validation (T0'+8), rises again; exactly two rising edges; final data_output==21'h1FFFFF.
- Reset mid-frame: assert rstn=0 during DATA idx 10 for 1 cycle while rx is held low → all outputs 0; the block waits in BREAK until rx is high; the following frame 21'h155555 is received correctly.
- Reset release with rx held low for 100 cycles → no frame, busy==1 (BREAK), ready==0.
